// File: rtl/edge_detect_stream.sv
// edge_detect_stream: RGB raster stream to grayscale, 3x3 window from two
// line buffers, then gray / Sobel magnitude / threshold / inverted magnitude.
// Three register stages: S1 gray + line-buffer read, S2 window shift,
// S3 Sobel and mode select into the output registers.
//
// Stream semantics: a pixel is accepted on every rising edge where
// pixel_valid=1 (sof is only meaningful together with pixel_valid). There is
// no backpressure on either side; out_valid is a one-cycle pulse that the
// consumer must take in that cycle.
module edge_detect_stream #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int CH_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3*CH_BITS-1:0] pixel_in,
    input  logic                 pixel_valid,
    input  logic                 sof,
    input  logic [1:0]           mode,
    input  logic [CH_BITS-1:0]   thresh,
    output logic [3*CH_BITS-1:0] pixel_out,
    output logic                 out_valid,
    output logic                 out_last
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW = CH_BITS + 8;
    localparam int SW = CH_BITS + 4;
    localparam logic [CW-1:0]      COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]      ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CH_BITS-1:0] PIX_MAX  = {CH_BITS{1'b1}};
    localparam logic [SW:0]        MAG_SAT  = {{(SW + 1 - CH_BITS){1'b0}}, PIX_MAX};

    // position counters and latched frame configuration
    logic [CW-1:0]      col_q;
    logic [RW-1:0]      row_q;
    logic [1:0]         mode_q;
    logic [CH_BITS-1:0] thresh_q;

    // line buffers: lb0 holds the previous row, lb1 the row before that
    logic [CH_BITS-1:0] lb0_q [0:IMG_W-1];
    logic [CH_BITS-1:0] lb1_q [0:IMG_W-1];

    // stage 1
    logic               s1_valid_q, s1_emit_q, s1_last_q;
    logic [CH_BITS-1:0] s1_gray_q, s1_top_q, s1_mid_q, s1_thresh_q;
    logic [1:0]         s1_mode_q;

    // stage 2: window, [row][col], row 0 = oldest line, col 2 = newest pixel
    logic [CH_BITS-1:0] win_q [0:2][0:2];
    logic               s2_valid_q, s2_last_q;
    logic [CH_BITS-1:0] s2_thresh_q;
    logic [1:0]         s2_mode_q;

    // stage 3 (outputs)
    logic [3*CH_BITS-1:0] pixel_out_q;
    logic                 out_valid_q, out_last_q;

    // combinational helpers
    logic               accept;
    logic [CW-1:0]      cur_col, nxt_col;
    logic [RW-1:0]      cur_row, nxt_row;
    logic [1:0]         eff_mode;
    logic [CH_BITS-1:0] eff_thresh;
    logic [GW-1:0]      r_x, g_x, b_x, gray_sum;
    logic [CH_BITS-1:0] gray;
    logic signed [SW-1:0] gx, gy;
    logic [SW-1:0]      gx_abs, gy_abs;
    logic [SW:0]        mag_sum;
    logic [CH_BITS-1:0] mag, result;

    function automatic logic signed [SW-1:0] px(input logic [CH_BITS-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    assign accept = pixel_valid;

    // position of the pixel being accepted (sof forces origin) and its successor
    always_comb begin
        cur_col    = sof ? '0 : col_q;
        cur_row    = sof ? '0 : row_q;
        eff_mode   = sof ? mode : mode_q;
        eff_thresh = sof ? thresh : thresh_q;
        nxt_col    = cur_col + CW'(1);
        nxt_row    = cur_row;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end
    end

    // grayscale with shift-add weights 77/150/29, then >> 8
    always_comb begin
        r_x = GW'(pixel_in[3*CH_BITS-1 -: CH_BITS]);
        g_x = GW'(pixel_in[2*CH_BITS-1 -: CH_BITS]);
        b_x = GW'(pixel_in[CH_BITS-1:0]);
        gray_sum = (r_x << 6) + (r_x << 3) + (r_x << 2) + r_x
                 + (g_x << 7) + (g_x << 4) + (g_x << 2) + (g_x << 1)
                 + (b_x << 4) + (b_x << 3) + (b_x << 2) + b_x;
        gray = CH_BITS'(gray_sum >> 8);
    end

    // counters, frame configuration and stage 1 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= '0;
            thresh_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_emit_q   <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_gray_q   <= '0;
            s1_top_q    <= '0;
            s1_mid_q    <= '0;
            s1_mode_q   <= '0;
            s1_thresh_q <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                col_q       <= nxt_col;
                row_q       <= nxt_row;
                if (sof) begin
                    mode_q   <= mode;
                    thresh_q <= thresh;
                end
                s1_emit_q   <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
                s1_last_q   <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
                s1_gray_q   <= gray;
                s1_top_q    <= lb1_q[cur_col];
                s1_mid_q    <= lb0_q[cur_col];
                s1_mode_q   <= eff_mode;
                s1_thresh_q <= eff_thresh;
            end
        end
    end

    // line buffer update: shift this column down one line, store the new gray
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[cur_col] <= lb0_q[cur_col];
            lb0_q[cur_col] <= gray;
        end
    end

    // stage 2: shift the 3x3 window left by one column per accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_mode_q   <= '0;
            s2_thresh_q <= '0;
        end else begin
            s2_valid_q <= s1_valid_q && s1_emit_q;
            if (s1_valid_q) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= s1_top_q;
                win_q[1][2] <= s1_mid_q;
                win_q[2][2] <= s1_gray_q;
                s2_last_q   <= s1_last_q;
                s2_mode_q   <= s1_mode_q;
                s2_thresh_q <= s1_thresh_q;
            end
        end
    end

    // Sobel magnitude with saturation and mode selection
    always_comb begin
        gx = (px(win_q[0][2]) + (px(win_q[1][2]) <<< 1) + px(win_q[2][2]))
           - (px(win_q[0][0]) + (px(win_q[1][0]) <<< 1) + px(win_q[2][0]));
        gy = (px(win_q[2][0]) + (px(win_q[2][1]) <<< 1) + px(win_q[2][2]))
           - (px(win_q[0][0]) + (px(win_q[0][1]) <<< 1) + px(win_q[0][2]));
        gx_abs  = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
        gy_abs  = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag_sum = {1'b0, gx_abs} + {1'b0, gy_abs};
        mag     = (mag_sum > MAG_SAT) ? PIX_MAX : mag_sum[CH_BITS-1:0];
        case (s2_mode_q)
            2'd0:    result = win_q[1][1];
            2'd1:    result = mag;
            2'd2:    result = (mag > s2_thresh_q) ? PIX_MAX : '0;
            default: result = PIX_MAX - mag;
        endcase
    end

    // stage 3: registered output pulse; pixel_out holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= s2_valid_q;
            out_last_q  <= s2_valid_q && s2_last_q;
            if (s2_valid_q) begin
                pixel_out_q <= {3{result}};
            end
        end
    end

    assign pixel_out = pixel_out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_edge_detect_stream.sv
// Directed bench for edge_detect_stream at 8x6, 4-bit channels.
module tb_edge_detect_stream;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        sof = 1'b0;
    logic [1:0]  mode = '0;
    logic [3:0]  thresh = '0;
    logic [11:0] pixel_out;
    logic        out_valid;
    logic        out_last;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    logic [11:0] exp_q[$];
    logic        exp_last_q[$];
    int          exp_cyc_q[$];
    logic [11:0] obs_q[$];
    logic        obs_last_q[$];
    int          obs_cyc_q[$];

    edge_detect_stream #(.IMG_W(W), .IMG_H(H), .CH_BITS(4)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .sof(sof), .mode(mode), .thresh(thresh), .pixel_out(pixel_out),
        .out_valid(out_valid), .out_last(out_last)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (out_valid) begin
            obs_q.push_back(pixel_out);
            obs_last_q.push_back(out_last);
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // present one input cycle; acc returns the cycle in which it was presented
    task automatic drive(input logic v, input logic [11:0] p, input logic s,
                         input logic [1:0] m, input logic [3:0] t, output int acc);
        pixel_valid = v;
        pixel_in    = p;
        sof         = s;
        mode        = m;
        thresh      = t;
        acc         = cyc;
        @(posedge clk);
        #1;
    endtask

    // pattern 0: all 0xFFF, 1: all 0x888, 2: columns 0-3 black, 4-7 white
    function automatic logic [11:0] pix_of(input int pat, input int c);
        if (pat == 0) return 12'hFFF;
        if (pat == 1) return 12'h888;
        return (c < 4) ? 12'h000 : 12'hFFF;
    endfunction

    function automatic logic [3:0] gray_of(input int pat, input int c);
        if (pat == 0) return 4'd15;
        if (pat == 1) return 4'd8;
        return (c < 4) ? 4'd0 : 4'd15;
    endfunction

    // hand-derived: only the step at columns 3/4 has a gradient (|Gx|=60 -> 15)
    function automatic logic [3:0] mag_of(input int pat, input int c);
        return (pat == 2 && (c == 3 || c == 4)) ? 4'd15 : 4'd0;
    endfunction

    function automatic logic [11:0] res_of(input int pat, input logic [1:0] md,
                                           input logic [3:0] th, input int c);
        logic [3:0] g, m, r;
        g = gray_of(pat, c);
        m = mag_of(pat, c);
        case (md)
            2'd0:    r = g;
            2'd1:    r = m;
            2'd2:    r = (m > th) ? 4'd15 : 4'd0;
            default: r = 4'd15 - m;
        endcase
        return {r, r, r};
    endfunction

    task automatic send_frame(input int pat, input logic [1:0] md, input logic [3:0] th,
                              input int npix, input bit use_sof, input int gap_pct,
                              input bit expect_out);
        int acc;
        int r;
        int c;
        for (int i = 0; i < npix; i++) begin
            r = i / W;
            c = i % W;
            while ($urandom_range(99) < gap_pct)
                drive(1'b0, 12'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), acc);
            drive(1'b1, pix_of(pat, c), use_sof && (i == 0),
                  (i == 0) ? md : 2'($urandom), (i == 0) ? th : 4'($urandom), acc);
            if (expect_out && r >= 2 && c >= 2) begin
                exp_q.push_back(res_of(pat, md, th, c - 1));
                exp_last_q.push_back(r == H - 1 && c == W - 1);
                exp_cyc_q.push_back(acc + 3);
            end
        end
        pixel_valid = 1'b0;
        sof = 1'b0;
    endtask

    // scoreboard: drain, then compare observed outputs against the expected queue
    task automatic check_outputs(input string tag);
        int n;
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_val%0d", tag, i), obs_q[i], exp_q[i]);
            chk($sformatf("%s_last%0d", tag, i), obs_last_q[i], exp_last_q[i]);
            chk($sformatf("%s_cyc%0d", tag, i), obs_cyc_q[i], exp_cyc_q[i]);
        end
        if (exp_q.size() > 0)
            chk({tag, "_hold"}, pixel_out, exp_q[exp_q.size() - 1]);
        exp_q.delete(); exp_last_q.delete(); exp_cyc_q.delete();
        obs_q.delete(); obs_last_q.delete(); obs_cyc_q.delete();
    endtask

    initial begin
        int acc;
        @(posedge clk);
        #1;

        // reset held with pixel_valid toggling
        for (int k = 0; k < 8; k++) begin
            pixel_valid = 1'(k % 2);
            pixel_in    = 12'($urandom);
            sof         = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_last", out_last, 1'b0);
            chk("rst_pix", pixel_out, 12'h000);
        end
        pixel_valid = 1'b0;
        sof = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(1, 2'd0, 4'd0, W * H, 1'b1, 0, 1'b1);
        check_outputs("t1");

        // uniform white, Sobel magnitude
        send_frame(0, 2'd1, 4'd0, W * H, 1'b1, 0, 1'b1);
        check_outputs("t2");

        // uniform 0x888: gray, then a frame without sof, then inverted magnitude
        send_frame(1, 2'd0, 4'd0, W * H, 1'b1, 0, 1'b1);
        check_outputs("t3_gray");
        send_frame(1, 2'd0, 4'd0, W * H, 1'b0, 0, 1'b1);
        check_outputs("t3_nosof");
        send_frame(1, 2'd3, 4'd0, W * H, 1'b1, 0, 1'b1);
        check_outputs("t3_inv");

        // vertical step edge, magnitude and threshold
        send_frame(2, 2'd1, 4'd0, W * H, 1'b1, 0, 1'b1);
        check_outputs("t4_mag");
        send_frame(2, 2'd2, 4'd8, W * H, 1'b1, 0, 1'b1);
        check_outputs("t4_thr");

        // same with random valid gaps
        send_frame(2, 2'd1, 4'd0, W * H, 1'b1, 50, 1'b1);
        check_outputs("t5_mag");
        send_frame(2, 2'd2, 4'd8, W * H, 1'b1, 50, 1'b1);
        check_outputs("t5_thr");

        // sof arriving mid-frame at row 3, followed directly by a full frame
        send_frame(2, 2'd0, 4'd0, 3 * W + 4, 1'b1, 0, 1'b1);
        send_frame(2, 2'd1, 4'd0, W * H, 1'b1, 0, 1'b1);
        check_outputs("t6_sof");

        // reset pulse mid-frame kills the output already on the wire
        send_frame(2, 2'd1, 4'd0, 2 * W + 4, 1'b1, 0, 1'b0);
        drive(1'b0, 12'h000, 1'b0, 2'd0, 4'd0, acc);
        chk("t6_pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_last", out_last, 1'b0);
        chk("t6_rst_pix", pixel_out, 12'h000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("t6_rst");
        send_frame(2, 2'd1, 4'd0, W * H, 1'b1, 0, 1'b1);
        check_outputs("t6_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
